// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous clear and load.
// Wrap or saturate at terminal count, sticky overflow, rejected-load pulse.
module bcd_updown_counter #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] step_val;
    logic         all_nine;
    logic         all_zero;
    logic         load_ok;
    logic         term;
    logic         carry;
    logic [3:0]   dig;

    // Digit-wise step: a digit moves only while every lower digit rolls over.
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        load_ok  = 1'b1;
        carry    = 1'b1;
        step_val = count_q;
        dig      = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (dig != 4'd9) all_nine = 1'b0;
            if (dig != 4'd0) all_zero = 1'b0;
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
            if (carry) begin
                if (up) begin
                    step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : 4'(dig + 4'd1);
                    carry              = (dig == 4'd9);
                end else begin
                    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : 4'(dig - 4'd1);
                    carry              = (dig == 4'd0);
                end
            end
        end
    end

    assign term = up ? all_nine : all_zero;
    assign tc   = en & term;

    // Priority clr > load > en; a rejected load still blocks counting.
    always_comb begin
        count_d    = count_q;
        ovf_d      = ovf_q;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            if (load_ok) count_d = load_val;
            else         load_err_d = 1'b1;
        end else if (en) begin
            if (term) begin
                ovf_d = 1'b1;
                if (SAT_MODE == 0) count_d = step_val;
            end else begin
                count_d = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign ovf      = ovf_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three configurations share stimulus and are
// compared each cycle against an integer-valued model of the counter.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [31:0] lv = '0;

    logic [7:0]  cnt_a, cnt_b;
    logic [15:0] cnt_c;
    logic        tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c, lerr_a, lerr_b, lerr_c;

    int n_err = 0;
    int n_chk = 0;

    int m_val[3]  = '{0, 0, 0};
    bit m_ovf[3]  = '{0, 0, 0};
    bit m_lerr[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .SAT_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_a), .tc(tc_a), .ovf(ovf_a), .load_err(lerr_a));
    bcd_updown_counter #(.DIGITS(2), .SAT_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_b), .tc(tc_b), .ovf(ovf_b), .load_err(lerr_b));
    bcd_updown_counter #(.DIGITS(4), .SAT_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[15:0]), .count(cnt_c), .tc(tc_c), .ovf(ovf_c), .load_err(lerr_c));

    function automatic int dg(int k);
        return (k == 2) ? 4 : 2;
    endfunction

    function automatic bit sat(int k);
        return (k == 1);
    endfunction

    function automatic int pow10(int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(int v, int d);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit lv_valid(logic [31:0] v, int d);
        for (int i = 0; i < d; i++)
            if (((v >> (4 * i)) & 32'hF) > 32'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int lv_int(logic [31:0] v, int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'((v >> (4 * i)) & 32'hF);
        return r;
    endfunction

    function automatic logic [31:0] act_cnt(int k);
        case (k)
            0:       return {24'd0, cnt_a};
            1:       return {24'd0, cnt_b};
            default: return {16'd0, cnt_c};
        endcase
    endfunction

    function automatic logic [2:0] act_flags(int k);
        case (k)
            0:       return {tc_a, ovf_a, lerr_a};
            1:       return {tc_b, ovf_b, lerr_b};
            default: return {tc_c, ovf_c, lerr_c};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counter value held as a plain integer modulo 10^DIGITS.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            int top;
            top = pow10(dg(k)) - 1;
            if (!rst_n) begin
                m_val[k] = 0; m_ovf[k] = 1'b0; m_lerr[k] = 1'b0;
            end else begin
                m_lerr[k] = 1'b0;
                if (clr) begin
                    m_val[k] = 0; m_ovf[k] = 1'b0;
                end else if (load) begin
                    if (lv_valid(lv, dg(k))) m_val[k] = lv_int(lv, dg(k));
                    else                     m_lerr[k] = 1'b1;
                end else if (en) begin
                    if (up) begin
                        if (m_val[k] == top) begin
                            m_ovf[k] = 1'b1;
                            if (!sat(k)) m_val[k] = 0;
                        end else m_val[k] = m_val[k] + 1;
                    end else begin
                        if (m_val[k] == 0) begin
                            m_ovf[k] = 1'b1;
                            if (!sat(k)) m_val[k] = top;
                        end else m_val[k] = m_val[k] - 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                logic exp_tc;
                exp_tc = en && (up ? (m_val[k] == pow10(dg(k)) - 1) : (m_val[k] == 0));
                chk($sformatf("count[%0d]", k), act_cnt(k), to_bcd(m_val[k], dg(k)));
                chk($sformatf("flags[%0d] tc/ovf/lerr", k), 32'(act_flags(k)),
                    32'({exp_tc, m_ovf[k], m_lerr[k]}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        chk("reset count", {24'd0, cnt_a}, 32'h0);
        chk("reset ovf/lerr", {30'd0, ovf_a, lerr_a}, 32'h0);

        // Up-count to 99 then wrap; saturating copy holds at 99.
        en = 1'b1; up = 1'b1;
        repeat (99) tick();
        chk("up 99 edges", {24'd0, cnt_a}, 32'h99);
        chk("tc at 99", {31'd0, tc_a}, 32'h1);
        tick();
        chk("wrap count", {24'd0, cnt_a}, 32'h00);
        chk("wrap ovf", {31'd0, ovf_a}, 32'h1);
        chk("sat hold 99", {24'd0, cnt_b}, 32'h99);
        chk("sat ovf", {31'd0, ovf_b}, 32'h1);

        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        chk("clr ovf", {31'd0, ovf_a}, 32'h0);

        en = 1'b1; up = 1'b0; tick(); en = 1'b0;
        chk("down wrap", {24'd0, cnt_a}, 32'h99);
        chk("down wrap ovf", {31'd0, ovf_a}, 32'h1);
        chk("down sat", {24'd0, cnt_b}, 32'h00);
        chk("down sat ovf", {31'd0, ovf_b}, 32'h1);

        clr = 1'b1; load = 1'b1; lv = 32'h47; en = 1'b1; up = 1'b1; tick();
        chk("prio count", {24'd0, cnt_a}, 32'h00);
        chk("prio ovf", {31'd0, ovf_a}, 32'h0);

        clr = 1'b0; en = 1'b0; load = 1'b1; lv = 32'h47; tick();
        chk("load 47", {24'd0, cnt_a}, 32'h47);
        chk("load 47 lerr", {31'd0, lerr_a}, 32'h0);
        lv = 32'h4A; tick();
        chk("load 4A hold", {24'd0, cnt_a}, 32'h47);
        chk("load 4A lerr", {31'd0, lerr_a}, 32'h1);
        load = 1'b0; tick();
        chk("lerr one cycle", {31'd0, lerr_a}, 32'h0);

        load = 1'b1; lv = 32'h0999; tick(); load = 1'b0;
        en = 1'b1; up = 1'b1; tick();
        chk("carry up", {16'd0, cnt_c}, 32'h1000);
        up = 1'b0; tick();
        chk("borrow down", {16'd0, cnt_c}, 32'h0999);

        up = 1'b1; tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async rst count", {16'd0, cnt_c}, 32'h0);
        chk("async rst flags", {29'd0, ovf_c, lerr_c, ovf_a}, 32'h0);
        tick();
        rst_n = 1'b1; en = 1'b0;

        // Randomized traffic, with near-terminal loads to reach the wrap points.
        for (int n = 0; n < 3000; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            clr  = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: lv = 32'h99999999;
                1: lv = 32'h0;
                2: begin
                    lv = '0;
                    for (int i = 0; i < 8; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
                end
                default: lv = $urandom;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rand async rst", {24'd0, cnt_b}, 32'h0);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits; legal range 1..8.
REQ-002 The block SHALL have parameter SAT_MODE, default 0: 0 = wrap at terminal count, 1 = saturate at terminal count.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 The block SHALL have port load_val, input, 4*DIGITS bits: BCD load value, digit 0 in bits [3:0].
REQ-010 The block SHALL have port count, output, 4*DIGITS bits: registered BCD count, digit 0 in bits [3:0].
REQ-011 The block SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-012 The block SHALL have port ovf, output, 1 bit: sticky wrap/saturation flag, registered.
REQ-013 The block SHALL have port load_err, output, 1 bit: registered 1-cycle pulse on a rejected load.

Function
REQ-014 The block SHALL apply per-edge priority: clr > load > en; with none active, count, ovf and the direction state hold.
REQ-015 clr=1 SHALL set count to all zeros and ovf to 0, and load_err to 0, on the next edge.
REQ-016 load=1 with every load_val digit in 0..9 SHALL set count to load_val on the next edge; ovf SHALL be unchanged.
REQ-017 load=1 with any load_val digit in 10..15 SHALL leave count unchanged; load_err SHALL be 1 for exactly the following cycle.
REQ-018 load_err SHALL be 0 in every cycle not covered by REQ-017.
REQ-019 When en=1 and up=1, digit i SHALL increment iff all digits below i equal 9; a digit at 9 that increments SHALL become 0.
REQ-020 When en=1 and up=0, digit i SHALL decrement iff all digits below i equal 0; a digit at 0 that decrements SHALL become 9.
REQ-021 Digit 0 SHALL always step when en=1; count latency is one edge.
REQ-022 tc SHALL be 1 iff en=1 and either (up=1 and every digit = 9) or (up=0 and every digit = 0); clr and load do not mask tc.
REQ-023 With SAT_MODE=0, an enabled step at terminal count SHALL wrap: all 9s to all 0s when counting up, all 0s to all 9s when counting down.
REQ-024 With SAT_MODE=1, an enabled step at terminal count SHALL leave count unchanged.
REQ-025 An enabled step at terminal count, without clr or load in the same cycle, SHALL set ovf to 1 on that edge in either mode.
REQ-026 ovf, once set, SHALL remain 1 until clr or reset.
REQ-027 A direction change SHALL take effect on the same edge; no pipeline state depends on up.
REQ-028 The count register SHALL never hold a digit value above 9.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force count to all zeros, ovf to 0 and load_err to 0.
REQ-030 While rst_n=0, clr, load and en SHALL be ignored.
REQ-031 The first rising clk edge after rst_n rises SHALL be a normal functional edge.

Verification
REQ-032 Reset, DIGITS=2: rst_n=0 asserted between clock edges -> count=0x00, ovf=0, load_err=0 before the next edge.
REQ-033 Up-count wrap, SAT_MODE=0, DIGITS=2: en=1, up=1 from 0x00 for 99 edges -> count=0x99 with tc=1 -> next edge count=0x00 and ovf=1.
REQ-034 Down-count at zero, DIGITS=2, en=1, up=0 from 0x00: SAT_MODE=0 -> one edge gives count=0x99 and ovf=1; SAT_MODE=1 -> count stays 0x00, ovf=1.
REQ-035 Load check: load=1, load_val=0x47 -> count=0x47, load_err=0; then load_val=0x4A -> count stays 0x47, load_err=1 for one cycle.
REQ-036 Priority: clr=1, load=1 and en=1 in the same cycle with ovf=1 -> count=0x00 and ovf=0.
REQ-037 Carry chain, DIGITS=4: load 0x0999 then one up step -> count=0x1000; then one down step -> count=0x0999.
